playback_controller: RTL and testbench
======================================

// Module: playback_controller
// PURPOSE
//  Top-level sequencer for the music player datapath.
//  - Turns one-cycle play/next button pulses and the song_done pulse from song_reader into:
//    - the play level,
//    - the song select,
//    - a multi-cycle reset_player pulse that restarts song_reader and note_player at the new song.
//  - Sits between the button conditioning logic and song_reader/note_player.
// PARAMETERS
//  NUM_SONGS   4   songs in ROM; song index wraps modulo NUM_SONGS (2..4)
//  RST_CYCLES  4   cycles reset_player is held high per song change (1..15)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  play_button   in   1  one-cycle pulse: toggle play/pause
//  next_button   in   1  one-cycle pulse: skip to next song
//  song_done     in   1  one-cycle pulse from song_reader: current song finished
//  play          out  1  level to song_reader/note_player; 1 = advance notes
//  song          out  2  current song index to song_reader
//  reset_player  out  1  synchronous restart pulse to song_reader/note_player
//  busy          out  1  1 while in RESETTING
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-high, on the port named reset.
//  Outputs: all outputs are registered; each reacts one cycle after the causing input.
//  Reset values: state=PAUSED, play=0, song=0, reset_player=0, busy=0, resume=0, rst_cnt=0.
//  States:
//   - PAUSED: play=0.
//     - play_button -> PLAYING.
//     - next_button -> song=(song+1)%NUM_SONGS, resume=0, go to RESETTING.
//     - song_done is ignored.
//   - PLAYING: play=1.
//     - play_button alone -> PAUSED.
//     - next_button or song_done -> song=(song+1)%NUM_SONGS, resume=1, go to RESETTING.
//   - RESETTING: reset_player=1, play=0, busy=1. rst_cnt counts 0..RST_CYCLES-1.
//     - On the final count, go to PLAYING if resume=1, else PAUSED. rst_cnt clears to 0.
//     - play_button toggles resume. next_button and song_done are ignored.
//  Simultaneous events:
//   - next_button and song_done in the same cycle: advance exactly once.
//   - play_button with next_button or song_done in PLAYING: advance, and resume=0.
//   - play_button with next_button in PAUSED: advance, and resume=1.
//  Last song: song_done while song==NUM_SONGS-1 wraps song to 0; resume follows the optional feature.
//  Reset mid-RESETTING: immediate return to the reset values; reset_player drops asynchronously.
//  Arithmetic: song increment is 2-bit with an explicit wrap at NUM_SONGS-1 (not a bare overflow).
//  Illegal state encoding: recovers to PAUSED with all outputs at their reset values.
// CONFIGURATION
//  LOOP_ALL_EN defined:
//   - song_done on the last song wraps to song 0 with resume=1.
//   - Playback continues indefinitely.
//  LOOP_ALL_EN undefined:
//   - song_done on the last song wraps to song 0 with resume=0.
//   - The player stops in PAUSED at song 0 after RESETTING.
//   - next_button on the last song still wraps and keeps the current resume rule.
// TESTING
//  1 reset, then play_button -> play=1 next cycle, song=0, reset_player=0.
//  2 PLAYING song 0, next_button -> song=1, reset_player=1 and busy=1 for 4 cycles, then play=1.
//  3 PLAYING, play_button and song_done same cycle -> song+1, RESETTING, ends in PAUSED (play=0).
//  4 PLAYING song 3, song_done -> song=0; play=1 after 4 cycles iff LOOP_ALL_EN, else play=0.
//  5 PAUSED, next_button x5 each spaced past RESETTING -> song 1,2,3,0,1; play stays 0.
//  6 reset asserted in 2nd RESETTING cycle -> reset_player=0 and song=0 before next clk edge.
//  7 RESETTING from PAUSED, play_button at cycle 2 -> ends in PLAYING (play=1).

Source files
------------

// File: rtl/playback_controller.sv
// Play/pause/next sequencer for the music player; drives play, song and a restart pulse.
// Build option LOOP_ALL_EN: song_done on the last song wraps to song 0 and keeps playing.
module playback_controller #(
  parameter int NUM_SONGS  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       song_done,
  output logic       play,
  output logic [1:0] song,
  output logic       reset_player,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_PAUSED    = 2'b00,
    S_PLAYING   = 2'b01,
    S_RESETTING = 2'b10
  } state_t;

  localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);
  localparam logic [3:0] CNT_LAST  = 4'(RST_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_song, w_song_nxt, w_song_inc;
  logic       r_resume, w_resume_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_play, r_rst_player, r_busy;
  logic       w_last;

  assign w_last     = (r_song == LAST_SONG);
  assign w_song_inc = w_last ? 2'd0 : r_song + 2'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_song_nxt   = r_song;
    w_resume_nxt = r_resume;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_PAUSED: begin
        if (next_button) begin
          w_song_nxt   = w_song_inc;
          w_resume_nxt = play_button;
          w_cnt_nxt    = 4'd0;
          w_state_nxt  = S_RESETTING;
        end else if (play_button) begin
          w_state_nxt = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (next_button || song_done) begin
          w_song_nxt   = w_song_inc;
          w_resume_nxt = !play_button;
`ifndef LOOP_ALL_EN
          // Finishing the last song stops the player at song 0.
          if (song_done && w_last) w_resume_nxt = 1'b0;
`endif
          w_cnt_nxt    = 4'd0;
          w_state_nxt  = S_RESETTING;
        end else if (play_button) begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_RESETTING: begin
        w_resume_nxt = r_resume ^ play_button;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_resume_nxt ? S_PLAYING : S_PAUSED;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt  = S_PAUSED;
        w_song_nxt   = 2'd0;
        w_resume_nxt = 1'b0;
        w_cnt_nxt    = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they follow the input by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_PAUSED;
      r_song       <= 2'd0;
      r_resume     <= 1'b0;
      r_cnt        <= 4'd0;
      r_play       <= 1'b0;
      r_rst_player <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_song       <= w_song_nxt;
      r_resume     <= w_resume_nxt;
      r_cnt        <= w_cnt_nxt;
      r_play       <= (w_state_nxt == S_PLAYING);
      r_rst_player <= (w_state_nxt == S_RESETTING);
      r_busy       <= (w_state_nxt == S_RESETTING);
    end
  end

  assign play         = r_play;
  assign song         = r_song;
  assign reset_player = r_rst_player;
  assign busy         = r_busy;

endmodule

// File: tb/tb_playback_controller.sv
// Self-checking bench for playback_controller: vector table plus hand-written corner sequences.
module tb_playback_controller;

`ifdef LOOP_ALL_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, song_done;
  logic       play, reset_player, busy;
  logic [1:0] song;

  playback_controller #(.NUM_SONGS(4), .RST_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .play_button(play_button), .next_button(next_button), .song_done(song_done),
    .play(play), .song(song), .reset_player(reset_player), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       p, n, d;
    bit       e_play;
    bit [1:0] e_song;
    bit       e_rp, e_busy;
  } vec_t;

  typedef struct {
    bit [4:0] outs;
    string    name;
  } exp_t;

  exp_t q[$];
  vec_t tbl[22];
  int   n_tests = 0;
  int   n_failed = 0;

  function automatic vec_t v(bit p, bit n, bit d, bit ep, bit [1:0] es, bit er, bit eb);
    vec_t r;
    r.p = p; r.n = n; r.d = d;
    r.e_play = ep; r.e_song = es; r.e_rp = er; r.e_busy = eb;
    return r;
  endfunction

  task automatic compare(input string name, input bit [4:0] got, input bit [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got {play,song,rst,busy}=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic step(input string name, input bit p, input bit n, input bit d,
                      input bit ep, input bit [1:0] es, input bit er, input bit eb);
    exp_t e;
    @(negedge clk);
    play_button = p; next_button = n; song_done = d;
    e.outs = {ep, es, er, eb};
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
    play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
    if (q.size() == 0) begin
      n_tests++; n_failed++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = q.pop_front();
      compare(e.name, {play, song, reset_player, busy}, e.outs);
    end
  endtask

  // Three more RESETTING cycles, then the final state.
  task automatic tail(input string name, input bit [1:0] es, input bit ep);
    for (int k = 0; k < 3; k++) step(name, 1'b0, 1'b0, 1'b0, 1'b0, es, 1'b1, 1'b1);
    step({name, "_end"}, 1'b0, 1'b0, 1'b0, ep, es, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = v(1,0,0, 1,2'd0,0,0);
    tbl[1]  = v(0,0,0, 1,2'd0,0,0);
    tbl[2]  = v(0,1,0, 0,2'd1,1,1);
    tbl[3]  = v(0,0,0, 0,2'd1,1,1);
    tbl[4]  = v(0,0,0, 0,2'd1,1,1);
    tbl[5]  = v(0,0,0, 0,2'd1,1,1);
    tbl[6]  = v(0,0,0, 1,2'd1,0,0);
    tbl[7]  = v(1,0,1, 0,2'd2,1,1);
    tbl[8]  = v(0,0,0, 0,2'd2,1,1);
    tbl[9]  = v(0,0,0, 0,2'd2,1,1);
    tbl[10] = v(0,0,0, 0,2'd2,1,1);
    tbl[11] = v(0,0,0, 0,2'd2,0,0);
    tbl[12] = v(0,1,0, 0,2'd3,1,1);
    tbl[13] = v(0,0,0, 0,2'd3,1,1);
    tbl[14] = v(1,0,0, 0,2'd3,1,1);
    tbl[15] = v(0,0,0, 0,2'd3,1,1);
    tbl[16] = v(0,0,0, 1,2'd3,0,0);
    tbl[17] = v(0,0,1, 0,2'd0,1,1);
    tbl[18] = v(0,0,0, 0,2'd0,1,1);
    tbl[19] = v(0,0,0, 0,2'd0,1,1);
    tbl[20] = v(0,0,0, 0,2'd0,1,1);
    tbl[21] = v(0,0,0, LOOP,2'd0,0,0);

    reset = 1'b1; play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
    #12;
    compare("reset_values", {play, song, reset_player, busy}, 5'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++)
      step($sformatf("vec%0d", i), tbl[i].p, tbl[i].n, tbl[i].d,
           tbl[i].e_play, tbl[i].e_song, tbl[i].e_rp, tbl[i].e_busy);

    @(negedge clk);
    reset = 1'b1;
    #1;
    compare("reset_again", {play, song, reset_player, busy}, 5'b0);
    @(negedge clk);
    reset = 1'b0;

    // Paused skips: song walks 1,2,3,0,1 and play stays low.
    for (int k = 1; k <= 5; k++) begin
      step($sformatf("skip%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 2'(k % 4), 1'b1, 1'b1);
      tail($sformatf("skip%0d", k), 2'(k % 4), 1'b0);
    end

    step("play_s1", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    step("next_done", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1);
    tail("next_done", 2'd2, 1'b1);

    step("pause_s2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    step("paused_play_next", 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1);
    tail("paused_play_next", 2'd3, 1'b1);

    step("next_last", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    tail("next_last", 2'd0, 1'b1);

    // Reset during the second RESETTING cycle clears outputs before the next edge.
    step("rst_mid_a", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    step("rst_mid_b", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    compare("rst_mid_async", {play, song, reset_player, busy}, 5'b0);
    @(negedge clk);
    reset = 1'b0;
    step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
